pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register for the CPU datapath: next generation of the enable/clear stage flop. Adds a valid/ready handshake and a one-entry skid buffer, so a stage boundary sustains one transfer per cycle. `in_ready` is driven from a register only, so it never depends combinationally on downstream `out_ready`. Synchronous flush (pipeline clear on branch/exception) and asynchronous reset are both supported.

---
 rtl/pipe_stage_skid.sv | 66 ++++++
 tb/tb_pipe_stage_skid.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with a one-entry skid buffer and registered in_ready
module pipe_stage_skid #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic accept, deq;
  assign out_valid = state_q != EMPTY;
  assign in_ready  = state_q != FULL;
  assign out_data  = main_q;
  assign count     = state_q;
  assign accept    = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  // state, head and skid registers; reset discards everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
  // next state and storage moves; flush overrides any accept or deq
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_VAL;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_d  = in_data;
          state_d = BUSY;
        end
        BUSY: if (accept && deq) main_d = in_data;
          else if (accept) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (deq) state_d = EMPTY;
        FULL: if (deq) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [31:0] in_data = '0, out_data;
  logic [1:0] count;
  int errors = 0, checks = 0;
  logic [31:0] q[$];

  pipe_stage_skid #(.WIDTH(32), .RST_VAL(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(posedge clk); #1;
  endtask

  // monitor: compare handshake outputs against the reference queue, then update it
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      chk("count_model", 32'(count), 32'(q.size()));
      chk("out_valid_model", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready_model", 32'(in_ready), 32'(q.size() != 2));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", out_data, 32'hxxxx_xxxx);
        else chk("beat_order", out_data, q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(in_data);
    end
  end

  initial begin
    logic pend;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", out_data, 0);
    rst = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1, 32'(i), 1, 0);
      chk("stream_count", 32'(count), 1);
      chk("stream_data", out_data, 32'(i));
    end
    step(0, 0, 1, 0);
    chk("stream_drain", 32'(count), 0);
    step(1, 32'h20, 1, 0);
    step(1, 32'h21, 0, 0);
    chk("skid_count", 32'(count), 2);
    chk("skid_in_ready", 32'(in_ready), 0);
    chk("skid_head", out_data, 32'h20);
    step(1, 32'h22, 0, 0);
    chk("skid_hold_count", 32'(count), 2);
    chk("skid_hold_head", out_data, 32'h20);
    step(1, 32'h22, 1, 0);
    chk("skid_pop1", out_data, 32'h21);
    chk("skid_pop1_count", 32'(count), 1);
    step(1, 32'h22, 1, 0);
    chk("skid_pop2", out_data, 32'h22);
    step(0, 0, 1, 0);
    chk("skid_drain", 32'(count), 0);
    step(1, 32'h30, 0, 0);
    step(1, 32'h31, 0, 0);
    chk("flush_pre_count", 32'(count), 2);
    step(1, 32'h32, 0, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_out_data", out_data, 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_out_valid", 32'(out_valid), 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 32'h40, 1, 0);
    chk("busy_head", out_data, 32'h40);
    step(1, 32'h41, 1, 0);
    chk("both_data", out_data, 32'h41);
    chk("both_count", 32'(count), 1);
    step(0, 0, 1, 0);
    step(1, 32'hA, 0, 0);
    step(1, 32'hB, 0, 0);
    chk("pre_rst_count", 32'(count), 2);
    #2 rst = 1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_in_ready", 32'(in_ready), 1);
    chk("async_rst_out_data", out_data, 0);
    in_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    step(1, 32'h55, 1, 0);
    chk("post_rst_accept", out_data, 32'h55);
    chk("post_rst_count", 32'(count), 1);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      pend = in_valid && !in_ready && !flush;
      step(pend ? 1'b1 : 1'($urandom_range(0, 1)),
           pend ? in_data : $urandom,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 49) == 0);
    end
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("final_empty", 32'(count), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
